aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. Accepts one plaintext block per valid/ready handshake, performs the initial AddRoundKey internally, then runs 10 rounds through an external combinational round function. It selects the round key from the 1408-bit expanded key, flags the final round (no MixColumns), and presents the ciphertext on a valid/ready output. It sits between the key-expansion block and the system bus, and owns the only state register of the encrypt path.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported; any other value is an elaboration error.
KEY_W, 128, state and round-key width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext offered
in_ready  output  1  controller accepts plaintext this cycle
plain_text  input  128  plaintext block
expanded_key  input  1408  round keys 0..10; key r = bits [1407-128r -: 128], key 0 in the MSBs
round_state_o  output  128  current state to the round function
round_key_o  output  128  round key for the current round
round_last_o  output  1  high during round NR: the round function skips MixColumns
round_result_i  input  128  combinational round-function result (same cycle)
out_valid  output  1  ciphertext available
out_ready  input  1  downstream accepts ciphertext
cypher_text  output  128  ciphertext (the state register while out_valid is high)
busy  output  1  high in ROUND or DONE
round_idx  output  4  current round 1..10; 0 when not in ROUND

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registers: state_q[127:0], cnt_q[3:0], rdy_q.
- Reset (rst_n low, asynchronous): FSM=IDLE, state_q=0, cnt_q=0, rdy_q=0. All outputs read 0: in_ready, out_valid, cypher_text, busy, round_idx, round_last_o, round_key_o=0, round_state_o=0.
- rdy_q is set on the first clk edge after rst_n deasserts. in_ready stays 0 until then.
- in_ready = rdy_q & (FSM==IDLE | (FSM==DONE & out_ready)). The combinational path from out_ready is allowed.
- Accept (in_valid & in_ready): state_q <= plain_text ^ key0; cnt_q <= 1; FSM <= ROUND.
- ROUND:
  - round_state_o = state_q; round_key_o = key[cnt_q]; round_last_o = (cnt_q==NR); round_idx = cnt_q.
  - On each edge, state_q <= round_result_i.
  - If cnt_q==NR, FSM <= DONE; otherwise cnt_q++.
  - in_valid is ignored during ROUND.
- DONE: out_valid=1, cypher_text=state_q. state_q is held until out_valid & out_ready.
  - Handshake with no new input: FSM <= IDLE, cnt_q <= 0.
  - Handshake with in_valid in the same cycle: the new block is accepted (back-to-back) and FSM goes directly to ROUND.
- Outside ROUND: round_key_o=0, round_state_o=state_q, round_last_o=0. Outside DONE: cypher_text=0.
- Latency: accept edge E0, round edges E1..E10. out_valid is high in the cycle after E10, i.e. 11 cycles from accept to first possible output handshake. Peak throughput is 1 block per 11 cycles.
- expanded_key is not latched. Upstream holds it stable from accept until the final round edge. A change mid-operation corrupts the result with no error.
- rst_n asserted mid-operation: the in-flight block is discarded; the reset values above apply immediately.
- Backpressure: out_ready low holds DONE indefinitely; cypher_text stays stable and in_ready stays 0.

Test Plan:
- Reset: assert rst_n low mid-ROUND -> all outputs 0 immediately. in_ready=0 on the first edge after release and 1 on the second.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, bench round model -> cypher_text 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. round_idx steps 1..10, and round_last_o is high only at round_idx=10.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> second block accepted in the DONE-handshake cycle; outputs valid 11 cycles apart, both correct.
- Backpressure: out_ready=0 for 20 cycles after DONE -> out_valid and cypher_text stable, in_ready=0, no extra round activity; release -> a single handshake, then IDLE.
- Ignore during ROUND: toggle in_valid and plain_text during rounds 3-7 -> in_ready=0 and the result is unchanged from the C.1 value.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
//
// Purpose : plaintext-in / ciphertext-out handshake bundle of the iterative
//           AES-128 encryption sequencer.
//
// Signals :
//   in_valid    plaintext offered by the bus side
//   in_ready    sequencer accepts plaintext this cycle
//   plain_text  plaintext block
//   out_valid   ciphertext available
//   out_ready   bus side accepts ciphertext
//   cypher_text ciphertext block (zero while out_valid is low)
//
// Modports:
//   master  bus side (drives plaintext, consumes ciphertext)
//   slave   sequencer side (aes_round_ctrl)
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if #(
  parameter int KEY_W = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] plain_text;
  logic             out_valid;
  logic             out_ready;
  logic [KEY_W-1:0] cypher_text;

  modport master (
    output in_valid,
    output plain_text,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cypher_text
  );

  modport slave (
    input  in_valid,
    input  plain_text,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cypher_text
  );
endinterface : aes_round_ctrl_if

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose : iterative AES-128 encryption sequencer. One plaintext block is
//           accepted per handshake, whitened with round key 0, then walked
//           through NR rounds of an external combinational round function.
//           The result is held on the output handshake until consumed. This
//           block owns the only state register of the encrypt path.
//
// Ports   :
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bus             handshake bundle (slave modport): in_valid/in_ready/
//                   plain_text in, out_valid/out_ready/cypher_text out
//   expanded_key    round keys 0..NR, key r at [KEY_W*(NR+1)-1-KEY_W*r -: KEY_W]
//                   (key 0 in the MSBs); not latched, must stay stable from
//                   accept until the final round edge
//   round_state_o   current state to the round function
//   round_key_o     round key for the current round (0 outside ROUND)
//   round_last_o    high in round NR: round function skips MixColumns
//   round_result_i  combinational round-function result, same cycle
//   busy            high in ROUND or DONE
//   round_idx       current round 1..NR, 0 when not in ROUND
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_round_ctrl_if.slave           bus,
  input  logic [KEY_W*(NR+1)-1:0]   expanded_key,
  output logic [KEY_W-1:0]          round_state_o,
  output logic [KEY_W-1:0]          round_key_o,
  output logic                      round_last_o,
  input  logic [KEY_W-1:0]          round_result_i,
  output logic                      busy,
  output logic [3:0]                round_idx
);

  // Only the AES-128 schedule (10 rounds) is supported.
  if (NR != 10) begin : g_nr_check
    $error("aes_round_ctrl: NR must be 10 (AES-128 only)");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [KEY_W-1:0] state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rdy_q;

  logic             accept;
  logic [KEY_W-1:0] key0;
  logic [KEY_W-1:0] key_cur;

  // Round-key mux: unrolled compare against every legal index so that an
  // out-of-range counter can never produce an out-of-range part-select.
  function automatic logic [KEY_W-1:0] sel_key(
    input logic [KEY_W*(NR+1)-1:0] ek,
    input logic [3:0]              r
  );
    logic [KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i <= NR; i++) begin
      if (r == 4'(i)) k = ek[KEY_W*(NR+1-i)-1 -: KEY_W];
    end
    return k;
  endfunction

  assign key0    = expanded_key[KEY_W*(NR+1)-1 -: KEY_W];
  assign key_cur = sel_key(expanded_key, cnt_q);

  // in_ready may follow out_ready combinationally in DONE so that a new block
  // can be taken in the same cycle the previous ciphertext is consumed.
  assign bus.in_ready = rdy_q & ((fsm_q == S_IDLE) |
                                 ((fsm_q == S_DONE) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (accept) begin
          state_d = bus.plain_text ^ key0;
          cnt_d   = 4'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        // in_valid is ignored here; in_ready is low so accept cannot fire.
        state_d = round_result_i;
        if (cnt_q == 4'(NR)) begin
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (accept) begin
            // Back-to-back: the consumed state slot is reloaded at once.
            state_d = bus.plain_text ^ key0;
            cnt_d   = 4'd1;
            fsm_d   = S_ROUND;
          end else begin
            cnt_d = 4'd0;
            fsm_d = S_IDLE;
          end
        end
      end
      default: begin
        fsm_d = S_IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Holds in_ready low for the first edge after reset release.
      rdy_q   <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.out_valid   = (fsm_q == S_DONE);
  assign bus.cypher_text = (fsm_q == S_DONE) ? state_q : '0;
  assign busy            = (fsm_q == S_ROUND) | (fsm_q == S_DONE);
  assign round_idx       = (fsm_q == S_ROUND) ? cnt_q : 4'd0;
  assign round_last_o    = (fsm_q == S_ROUND) & (cnt_q == 4'(NR));
  assign round_key_o     = (fsm_q == S_ROUND) ? key_cur : '0;
  assign round_state_o   = state_q;

  // Ciphertext must not move while it is being back-pressured.
  a_hold_under_bp : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.cypher_text))
  );

  // The round counter stays within the legal key range while rounds run.
  a_cnt_range : assert property (
    @(posedge clk) disable iff (!rst_n)
    (fsm_q == S_ROUND) |-> (cnt_q >= 4'd1 && cnt_q <= 4'(NR))
  );

endmodule : aes_round_ctrl
